// File: rtl/sequenciador_resposta_tx_pkg.sv
// Shared types and constants for the UART response sequencer: FSM state codes,
// frame layout and the default watchdog limit.
package sequenciador_resposta_tx_pkg;

    localparam int LARGURA_QUADRO        = 16;
    localparam int LARGURA_WATCHDOG      = 16;
    localparam int CICLOS_TIMEOUT_PADRAO = 4096;

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        CARREGA  = 3'd1,
        INICIA0  = 3'd2,
        AGUARDA0 = 3'd3,
        PREPARA1 = 3'd4,
        INICIA1  = 3'd5,
        AGUARDA1 = 3'd6
    } estado_t;

    // Code byte in the upper half so it leaves the FIFO as byte 0.
    typedef struct packed {
        logic [7:0] codigo;
        logic [7:0] dado;
    } quadro_t;

endpackage

// File: rtl/sequenciador_resposta_tx_fila.sv
// Synchronous frame FIFO with wrap-around pointers; full/empty derive from an
// occupancy counter one bit wider than the pointers.
module fila_quadros
    import sequenciador_resposta_tx_pkg::*;
#(
    parameter int PROFUNDIDADE     = 4,
    parameter int LARGURA_PONTEIRO = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [LARGURA_QUADRO-1:0] dado_entrada,
    output logic [LARGURA_QUADRO-1:0] dado_saida,
    output logic                      cheia,
    output logic                      vazia
);

    localparam logic [LARGURA_PONTEIRO:0]   CAPACIDADE = (LARGURA_PONTEIRO+1)'(PROFUNDIDADE);
    localparam logic [LARGURA_PONTEIRO:0]   CONTA_UM   = (LARGURA_PONTEIRO+1)'(1);
    localparam logic [LARGURA_PONTEIRO-1:0] PTR_UM     = (LARGURA_PONTEIRO)'(1);

    logic [LARGURA_QUADRO-1:0]   memoria [PROFUNDIDADE];
    logic [LARGURA_PONTEIRO-1:0] ptr_escrita;
    logic [LARGURA_PONTEIRO-1:0] ptr_leitura;
    logic [LARGURA_PONTEIRO:0]   contagem;
    logic                        escreve;
    logic                        le;

    assign cheia      = (contagem == CAPACIDADE);
    assign vazia      = (contagem == '0);
    // Fullness is judged before any same-cycle pop, so a push while full is lost.
    assign escreve    = push && !cheia;
    assign le         = pop && !vazia;
    assign dado_saida = memoria[ptr_leitura];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_escrita <= '0;
            ptr_leitura <= '0;
            contagem    <= '0;
        end else begin
            if (escreve) ptr_escrita <= ptr_escrita + PTR_UM;
            if (le)      ptr_leitura <= ptr_leitura + PTR_UM;
            case ({escreve, le})
                2'b10:   contagem <= contagem + CONTA_UM;
                2'b01:   contagem <= contagem - CONTA_UM;
                default: contagem <= contagem;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (escreve) memoria[ptr_escrita] <= dado_entrada;
    end

endmodule

// File: rtl/sequenciador_resposta_tx.sv
// Feeds buffered 2-byte response frames to the UART transmitter, one
// start/done handshake per byte, with a watchdog on each done indication.
module sequenciador_resposta_tx
    import sequenciador_resposta_tx_pkg::*;
#(
    parameter int PROFUNDIDADE_FILA = 4,
    parameter int LARGURA_PONTEIRO  = 2,
    parameter int CICLOS_TIMEOUT    = CICLOS_TIMEOUT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       quadroValido,
    input  logic [7:0] codigoResposta,
    input  logic [7:0] dadoResposta,
    output logic       filaCheia,
    output logic       filaVazia,
    output logic       erroEstouro,
    output logic       erroTimeout,
    output logic       haDadosParaTransmitir,
    output logic [7:0] byteASerTransmitido,
    input  logic       indicaTransmissao,
    input  logic       bitsEstaoEnviados,
    output logic       ocupado
);

    localparam logic [LARGURA_WATCHDOG-1:0] LIMITE_WATCHDOG = LARGURA_WATCHDOG'(CICLOS_TIMEOUT - 1);
    localparam logic [LARGURA_WATCHDOG-1:0] WATCHDOG_UM     = LARGURA_WATCHDOG'(1);

    estado_t                     estado;
    quadro_t                     quadro_novo;
    quadro_t                     quadro_topo;
    logic [7:0]                  byte1;
    logic                        done_q;
    logic                        done_borda;
    logic [LARGURA_WATCHDOG-1:0] watchdog;
    logic                        pop;

    assign quadro_novo = '{codigo: codigoResposta, dado: dadoResposta};
    assign pop         = (estado == CARREGA);
    assign ocupado     = (estado != ESPERA);

    fila_quadros #(
        .PROFUNDIDADE     (PROFUNDIDADE_FILA),
        .LARGURA_PONTEIRO (LARGURA_PONTEIRO)
    ) u_fila (
        .clock        (clock),
        .reset        (reset),
        .push         (quadroValido),
        .pop          (pop),
        .dado_entrada (quadro_novo),
        .dado_saida   (quadro_topo),
        .cheia        (filaCheia),
        .vazia        (filaVazia)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) erroEstouro <= 1'b0;
        else       erroEstouro <= quadroValido && filaCheia;
    end

    // Done may be held for several cycles; only its rising edge advances the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q     <= 1'b0;
            done_borda <= 1'b0;
        end else begin
            done_q     <= bitsEstaoEnviados;
            done_borda <= bitsEstaoEnviados && !done_q;
        end
    end

    // byteASerTransmitido doubles as the byte-0 holding register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado                <= ESPERA;
            haDadosParaTransmitir <= 1'b0;
            byteASerTransmitido   <= '0;
            byte1                 <= '0;
            erroTimeout           <= 1'b0;
            watchdog              <= '0;
        end else begin
            haDadosParaTransmitir <= 1'b0;
            erroTimeout           <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (!filaVazia && !indicaTransmissao) estado <= CARREGA;
                end
                CARREGA: begin
                    byteASerTransmitido   <= quadro_topo.codigo;
                    byte1                 <= quadro_topo.dado;
                    haDadosParaTransmitir <= 1'b1;
                    estado                <= INICIA0;
                end
                INICIA0: begin
                    watchdog <= '0;
                    estado   <= AGUARDA0;
                end
                AGUARDA0: begin
                    if (done_borda) begin
                        estado <= PREPARA1;
                    end else if (watchdog == LIMITE_WATCHDOG) begin
                        erroTimeout <= 1'b1;
                        estado      <= ESPERA;
                    end else if (watchdog != '1) begin
                        watchdog <= watchdog + WATCHDOG_UM;
                    end
                end
                PREPARA1: begin
                    if (!indicaTransmissao && !bitsEstaoEnviados) begin
                        byteASerTransmitido   <= byte1;
                        haDadosParaTransmitir <= 1'b1;
                        estado                <= INICIA1;
                    end
                end
                INICIA1: begin
                    watchdog <= '0;
                    estado   <= AGUARDA1;
                end
                AGUARDA1: begin
                    if (done_borda) begin
                        estado <= ESPERA;
                    end else if (watchdog == LIMITE_WATCHDOG) begin
                        erroTimeout <= 1'b1;
                        estado      <= ESPERA;
                    end else if (watchdog != '1) begin
                        watchdog <= watchdog + WATCHDOG_UM;
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule
